// File: rtl/rram_adc_output_fifo_if.sv
// ADC-to-controller bus for the RRAM ADC output FIFO: sample strobe and
// column bits on the write side, pop request and status on the read side.
interface rram_adc_output_fifo_if;
  logic        adc_valid;
  logic [15:0] ADC_OUT0;
  logic [15:0] ADC_OUT1;
  logic [15:0] ADC_OUT2;
  logic        rd_en;
  logic        clear_flags;
  logic [31:0] data_out;
  logic        rd_valid;
  logic        full;
  logic        empty;
  logic [3:0]  count;
  logic        busy;
  logic        overflow;
  logic        underflow;

  // Controller / ADC side: drives strobes and samples status
  modport master (
    output adc_valid, ADC_OUT0, ADC_OUT1, ADC_OUT2, rd_en, clear_flags,
    input  data_out, rd_valid, full, empty, count, busy, overflow, underflow
  );

  // FIFO side
  modport slave (
    input  adc_valid, ADC_OUT0, ADC_OUT1, ADC_OUT2, rd_en, clear_flags,
    output data_out, rd_valid, full, empty, count, busy, overflow, underflow
  );
endinterface

// File: rtl/rram_adc_output_fifo.sv
// RRAM ADC output FIFO: packs one 16-column, 3-bit ADC sample into two
// 32-bit words (one nibble per column) and queues them in an 8-entry buffer.
// A sample is only accepted when both words fit, so a sample is never split.
module rram_adc_output_fifo (
  input  logic                   clk,
  input  logic                   rst,
  rram_adc_output_fifo_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, PUSH_LO, PUSH_HI} state_t;

  state_t      state;
  logic [31:0] mem [8];
  logic [2:0]  wr_ptr, rd_ptr;
  logic [3:0]  count;
  logic [15:0] lat0, lat1, lat2;
  logic [31:0] data_out;
  logic        rd_valid, overflow, underflow;

  logic        push, pop, accept, ovf_set, unf_set;
  logic [31:0] wr_word;

  // Nibble k = {0, bit2, bit1, bit0} of column k within the 8-column slice
  function automatic logic [31:0] pack8(input logic [7:0] b0, input logic [7:0] b1,
                                        input logic [7:0] b2);
    logic [31:0] w;
    w = '0;
    for (int k = 0; k < 8; k++) w[4*k +: 4] = {1'b0, b2[k], b1[k], b0[k]};
    return w;
  endfunction

  // Write/read decisions; free-space check uses count before this edge's pop
  always_comb begin
    push    = (state != IDLE);
    pop     = bus.rd_en && (count != 4'd0);
    accept  = bus.adc_valid && (state == IDLE) && (count <= 4'd6);
    ovf_set = bus.adc_valid && !accept;
    unf_set = bus.rd_en && (count == 4'd0);
    wr_word = (state == PUSH_LO) ? pack8(lat0[7:0], lat1[7:0], lat2[7:0])
                                 : pack8(lat0[15:8], lat1[15:8], lat2[15:8]);
  end

  // Storage array; no reset needed, validity is tracked by count
  always_ff @(posedge clk) begin
    if (push && !rst) mem[wr_ptr] <= wr_word;
  end

  // Packer FSM, pointers, count, read port and sticky flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      data_out  <= '0;
      rd_valid  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      lat0      <= '0;
      lat1      <= '0;
      lat2      <= '0;
    end else begin
      case (state)
        IDLE:    if (accept) begin
                   lat0  <= bus.ADC_OUT0;
                   lat1  <= bus.ADC_OUT1;
                   lat2  <= bus.ADC_OUT2;
                   state <= PUSH_LO;
                 end
        PUSH_LO: state <= PUSH_HI;
        default: state <= IDLE;
      endcase

      if (push) wr_ptr <= wr_ptr + 3'd1;
      if (pop) begin
        data_out <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + 3'd1;
      end
      rd_valid <= pop;
      count    <= count + {3'b000, push} - {3'b000, pop};

      // Set beats clear when both happen in one cycle
      if (ovf_set)              overflow  <= 1'b1;
      else if (bus.clear_flags) overflow  <= 1'b0;
      if (unf_set)              underflow <= 1'b1;
      else if (bus.clear_flags) underflow <= 1'b0;
    end
  end

  assign bus.data_out  = data_out;
  assign bus.rd_valid  = rd_valid;
  assign bus.count     = count;
  assign bus.full      = (count == 4'd8);
  assign bus.empty     = (count == 4'd0);
  assign bus.busy      = (state != IDLE);
  assign bus.overflow  = overflow;
  assign bus.underflow = underflow;
endmodule

// File: tb/tb_rram_adc_output_fifo.sv
// Bench for rram_adc_output_fifo: a queue-based model of the FIFO contents and
// pending sample words, compared against the DUT every cycle, plus literal
// expectations at the key points of each directed scenario.
module tb_rram_adc_output_fifo;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  rram_adc_output_fifo_if bus();
  rram_adc_output_fifo dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // ---------------- model ----------------
  logic [31:0] q[$];
  logic [31:0] pend[$];
  logic [31:0] m_dout;
  logic        m_rv, m_ovf, m_unf;
  bit          m_live = 0;

  function automatic logic [31:0] word_of(input logic [15:0] a0, input logic [15:0] a1,
                                          input logic [15:0] a2, input int base);
    logic [31:0] w;
    w = '0;
    for (int k = 0; k < 8; k++)
      w[4*k +: 4] = {1'b0, a2[base+k], a1[base+k], a0[base+k]};
    return w;
  endfunction

  always @(posedge clk) begin
    int  old_size;
    bit  old_busy;
    if (rst) begin
      q.delete(); pend.delete();
      m_dout = '0; m_rv = 0; m_ovf = 0; m_unf = 0;
      m_live = 1;
    end else if (m_live) begin
      old_size = q.size();
      old_busy = (pend.size() != 0);
      m_rv = 0;
      if (bus.rd_en && old_size > 0) begin
        m_dout = q.pop_front();
        m_rv   = 1;
      end
      if (old_busy) q.push_back(pend.pop_front());
      if (bus.clear_flags) begin m_ovf = 0; m_unf = 0; end
      if (bus.rd_en && old_size == 0) m_unf = 1;
      if (bus.adc_valid) begin
        if (old_busy || (8 - old_size) < 2) m_ovf = 1;
        else begin
          pend.push_back(word_of(bus.ADC_OUT0, bus.ADC_OUT1, bus.ADC_OUT2, 0));
          pend.push_back(word_of(bus.ADC_OUT0, bus.ADC_OUT1, bus.ADC_OUT2, 8));
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (m_live) begin
      check("data_out",  bus.data_out, m_dout);
      check("rd_valid",  {31'b0, bus.rd_valid}, {31'b0, m_rv});
      check("count",     {28'b0, bus.count}, q.size());
      check("full",      {31'b0, bus.full}, {31'b0, q.size() == 8});
      check("empty",     {31'b0, bus.empty}, {31'b0, q.size() == 0});
      check("busy",      {31'b0, bus.busy}, {31'b0, pend.size() != 0});
      check("overflow",  {31'b0, bus.overflow}, {31'b0, m_ovf});
      check("underflow", {31'b0, bus.underflow}, {31'b0, m_unf});
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.adc_valid = 0; bus.rd_en = 0; bus.clear_flags = 0;
  endtask

  task automatic sample(input logic [15:0] a0, input logic [15:0] a1, input logic [15:0] a2);
    bus.ADC_OUT0 = a0; bus.ADC_OUT1 = a1; bus.ADC_OUT2 = a2;
    bus.adc_valid = 1;
    step();
    bus.adc_valid = 0;
  endtask

  initial begin
    rst = 1;
    idle_in();
    bus.ADC_OUT0 = '0; bus.ADC_OUT1 = '0; bus.ADC_OUT2 = '0;
    step(); step();
    check("rst_empty", {31'b0, bus.empty}, 32'd1);
    check("rst_full",  {31'b0, bus.full},  32'd0);
    check("rst_busy",  {31'b0, bus.busy},  32'd0);
    check("rst_dout",  bus.data_out, 32'h0);
    rst = 0;

    // Single sample and two pops
    sample(16'hFFFF, 16'h0000, 16'h00FF);
    check("s1_busy", {31'b0, bus.busy}, 32'd1);
    step();
    check("s1_cnt1", {28'b0, bus.count}, 32'd1);
    step();
    check("s1_cnt2", {28'b0, bus.count}, 32'd2);
    bus.rd_en = 1; step();
    check("s1_w0", bus.data_out, 32'h55555555);
    check("s1_rv0", {31'b0, bus.rd_valid}, 32'd1);
    step();
    check("s1_w1", bus.data_out, 32'h11111111);
    bus.rd_en = 0; step();
    check("s1_rv_off", {31'b0, bus.rd_valid}, 32'd0);

    // Underflow on empty pop, data_out held
    bus.rd_en = 1; step(); bus.rd_en = 0;
    check("uf_rv", {31'b0, bus.rd_valid}, 32'd0);
    check("uf_dout", bus.data_out, 32'h11111111);
    check("uf_flag", {31'b0, bus.underflow}, 32'd1);
    bus.clear_flags = 1; step(); bus.clear_flags = 0;
    check("uf_clr", {31'b0, bus.underflow}, 32'd0);

    // Fill with 4 samples spaced 3 cycles, then overflow
    for (int i = 0; i < 4; i++) begin
      sample(16'h1234 * (i + 1), 16'hA5C3 ^ i[15:0], 16'h0F0F << i);
      step(); step();
    end
    check("fill_full", {31'b0, bus.full}, 32'd1);
    check("fill_cnt", {28'b0, bus.count}, 32'd8);
    sample(16'hFFFF, 16'hFFFF, 16'hFFFF);
    check("ovf_flag", {31'b0, bus.overflow}, 32'd1);
    check("ovf_cnt", {28'b0, bus.count}, 32'd8);
    bus.clear_flags = 1; bus.adc_valid = 1; step();   // set wins over clear
    bus.adc_valid = 0;
    check("ovf_setwins", {31'b0, bus.overflow}, 32'd1);
    step(); bus.clear_flags = 0;
    check("ovf_clr", {31'b0, bus.overflow}, 32'd0);

    // Drain 8 words across the pointer wrap
    bus.rd_en = 1;
    for (int i = 0; i < 8; i++) step();
    bus.rd_en = 0; step();
    check("drain_empty", {31'b0, bus.empty}, 32'd1);

    // Back-to-back strobe: only the first sample lands
    bus.ADC_OUT0 = 16'h00F0; bus.ADC_OUT1 = 16'h0F00; bus.ADC_OUT2 = 16'hF000;
    bus.adc_valid = 1; step(); step(); bus.adc_valid = 0;
    step();
    check("b2b_cnt", {28'b0, bus.count}, 32'd2);
    check("b2b_ovf", {31'b0, bus.overflow}, 32'd1);

    // Reach count=3, then pop during PUSH_LO
    sample(16'h8001, 16'h4002, 16'h2004); step(); step();
    bus.rd_en = 1; step(); bus.rd_en = 0;
    check("sp_cnt3", {28'b0, bus.count}, 32'd3);
    sample(16'hC3C3, 16'h3C3C, 16'h5AA5);
    bus.rd_en = 1; step(); bus.rd_en = 0;
    check("sp_lo_cnt", {28'b0, bus.count}, 32'd3);
    step();
    check("sp_hi_cnt", {28'b0, bus.count}, 32'd4);

    // Reset in PUSH_LO
    sample(16'h1111, 16'h2222, 16'h4444);
    rst = 1; step(); rst = 0;
    check("mr_cnt",  {28'b0, bus.count}, 32'd0);
    check("mr_busy", {31'b0, bus.busy}, 32'd0);
    check("mr_dout", bus.data_out, 32'h0);
    check("mr_ovf",  {31'b0, bus.overflow}, 32'd0);
    // First edge after reset accepts a sample
    sample(16'h0001, 16'h0002, 16'h0004);
    check("post_rst_busy", {31'b0, bus.busy}, 32'd1);
    step(); step();
    check("post_rst_cnt", {28'b0, bus.count}, 32'd2);

    // Short mixed-traffic run, checked by the per-cycle model
    for (int i = 0; i < 60; i++) begin
      bus.adc_valid   = ($urandom_range(0, 2) == 0);
      bus.rd_en       = ($urandom_range(0, 2) == 0);
      bus.clear_flags = ($urandom_range(0, 9) == 0);
      bus.ADC_OUT0 = 16'($urandom); bus.ADC_OUT1 = 16'($urandom); bus.ADC_OUT2 = 16'($urandom);
      step();
    end
    idle_in();
    step(); step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
